icache_line_fill_adapter: RTL and testbench

- Memory-side responder for the instruction cache's wide line-fill interface.
- Accepts one line request from the cache (mem_req_*) and issues NUM_BLOCKS sequential 32-bit reads on a narrow valid/ready memory port.
- Assembles the returned words into one line and returns it to the cache with a single-cycle ready pulse.
- Sits between the cache and the existing narrow instruction memory, replacing the direct wide-memory model.

---
 rtl/icache_fill_pkg.sv | 25 ++
 rtl/icache_line_fill_adapter_if.sv | 24 ++
 rtl/icache_line_fill_adapter_line_fill_buf.sv | 31 +++
 rtl/icache_line_fill_adapter.sv | 109 ++++++++++
 tb/tb_icache_line_fill_adapter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fill_pkg.sv
// Shared types and geometry helpers for the I-cache line-fill adapter.
package icache_fill_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StGap
    } fill_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Byte-offset width of one cache line.
    function automatic int unsigned offset_w(input int unsigned num_blocks);
        return $clog2(num_blocks * WORD_BYTES);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned off_w);
        logic [31:0] mask;
        mask = ~((32'd1 << off_w) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_line_fill_adapter_if.sv
// Line-fill bus: wide cache request side plus narrow memory read side.
interface icache_line_fill_adapter_if #(
    parameter int unsigned NUM_BLOCKS = 4
);
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [31:0]                mem_req_addr;
    logic [32*NUM_BLOCKS-1:0]   mem_req_rdata;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [31:0]                mem_addr;
    logic [31:0]                mem_rdata;

    // slave: the adapter. master: the cache and narrow memory around it.
    modport slave (
        input  mem_req_valid, mem_req_addr, mem_ready, mem_rdata,
        output mem_req_ready, mem_req_rdata, mem_valid, mem_addr
    );

    modport master (
        output mem_req_valid, mem_req_addr, mem_ready, mem_rdata,
        input  mem_req_ready, mem_req_rdata, mem_valid, mem_addr
    );
endinterface

// File: rtl/icache_line_fill_adapter_line_fill_buf.sv
// Line assembly buffer: NUM_BLOCKS x 32-bit slots, read out flat with word i at [32*i +: 32].
module line_fill_buf #(
    parameter  int unsigned NUM_BLOCKS = 4,
    localparam int unsigned IDX_W      = $clog2(NUM_BLOCKS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [31:0]               wdata_i,
    output logic [32*NUM_BLOCKS-1:0]  line_o
);
    logic [31:0] slot_q [NUM_BLOCKS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (we_i) begin
            slot_q[idx_i] <= wdata_i;
        end
    end

    always_comb begin
        line_o = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            line_o[32*i +: 32] = slot_q[i];
        end
    end
endmodule

// File: rtl/icache_line_fill_adapter.sv
// Serves a wide I-cache line fill with NUM_BLOCKS sequential narrow 32-bit reads.
// Define CRITICAL_WORD_FIRST_EN to start each fill at the requested word and wrap.
module icache_line_fill_adapter
    import icache_fill_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input logic                        clk,
    input logic                        reset,
    icache_line_fill_adapter_if.slave  bus
);
    localparam int unsigned     OFF_W     = offset_w(NUM_BLOCKS);
    localparam int unsigned     IDX_W     = OFF_W - 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_BLOCKS - 1);

    if (BLOCK_SIZE != WORD_BYTES) begin : g_bad_block_size
        $error("icache_line_fill_adapter: BLOCK_SIZE must be 4");
    end
    if (NUM_BLOCKS < 2 || (NUM_BLOCKS & (NUM_BLOCKS - 1)) != 0) begin : g_bad_num_blocks
        $error("icache_line_fill_adapter: NUM_BLOCKS must be a power of two >= 2");
    end

    fill_state_e      state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [IDX_W-1:0] beat_q, beat_d;   // word index within the line being read
    logic [IDX_W-1:0] cnt_q, cnt_d;     // beats completed before the current one
    logic             abort_q, abort_d;
    logic             slot_we;
    logic [32*NUM_BLOCKS-1:0] line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_req_valid) begin
                    base_d  = line_base(bus.mem_req_addr, OFF_W);
`ifdef CRITICAL_WORD_FIRST_EN
                    beat_d  = bus.mem_req_addr[OFF_W-1:2];
`else
                    beat_d  = '0;
`endif
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // An in-flight read is never withdrawn; a dropped request is remembered.
                if (!bus.mem_req_valid) abort_d = 1'b1;
                if (bus.mem_ready) state_d = StWait;
            end
            StWait: begin
                if (abort_q || !bus.mem_req_valid) begin
                    state_d = StGap;
                end else if (cnt_q == LAST_BEAT) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    beat_d  = beat_q + 1'b1;
                    state_d = StReq;
                end
            end
            StDone:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mem_valid     = (state_q == StReq);
        bus.mem_req_ready = (state_q == StDone);
        bus.mem_addr      = base_q | {{(32 - OFF_W){1'b0}}, beat_q, 2'b00};
        bus.mem_req_rdata = line;
        slot_we           = (state_q == StReq) && bus.mem_ready;
    end

    // Slot index equals mem_addr[OFF_W-1:2], so placement is independent of beat order.
    line_fill_buf #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_line_fill_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (slot_we),
        .idx_i   (beat_q),
        .wdata_i (bus.mem_rdata),
        .line_o  (line)
    );
endmodule

// File: tb/tb_icache_line_fill_adapter.sv
// Scoreboard bench for icache_line_fill_adapter with a latency-configurable narrow memory.
module tb_icache_line_fill_adapter;
    localparam int NB         = 4;
    localparam int LINE_BYTES = NB * 4;

    typedef struct {
        logic [32*NB-1:0] line;
        int               start;
        int               lat;
    } fill_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 1;
    bit   mem_stuck = 1'b0;
    int   wait_cnt = 0;

    fill_exp_t   exp_fills[$];
    logic [31:0] exp_reads[$];

    icache_line_fill_adapter_if #(.NUM_BLOCKS(NB)) bus ();

    icache_line_fill_adapter #(
        .NUM_BLOCKS (NB),
        .BLOCK_SIZE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic logic [32*NB-1:0] exp_line(input logic [31:0] base);
        logic [32*NB-1:0] l;
        for (int i = 0; i < NB; i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
        return l;
    endfunction

    task automatic push_reads(input logic [31:0] addr, input int nbeats);
        int first;
`ifdef CRITICAL_WORD_FIRST_EN
        first = int'((addr % LINE_BYTES) / 4);
`else
        first = 0;
`endif
        for (int k = 0; k < nbeats; k++)
            exp_reads.push_back(base_of(addr) + 32'(4 * ((first + k) % NB)));
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Narrow memory: answers mem_lat cycles after mem_valid rises, or holds mem_ready high.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.mem_ready = 1'b0;
                wait_cnt = 0;
            end else if (mem_stuck) begin
                bus.mem_ready = 1'b1;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                wait_cnt = 0;
            end else if (bus.mem_valid) begin
                if (wait_cnt >= mem_lat) bus.mem_ready = 1'b1;
                else wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
            bus.mem_rdata = bus.mem_ready ? mem_word(bus.mem_addr) : $urandom();
        end
    end

    // Monitor: pops expectations whenever the DUT completes a narrow read or a line fill.
    initial begin
        fill_exp_t   mf;
        logic [31:0] ma;
        bit          gap_pending;
        gap_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gap_pending = 1'b0;
            end else begin
                if (gap_pending) begin
                    checks++;
                    if (bus.mem_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL beat_gap: mem_valid got %b, expected 0", bus.mem_valid);
                    end
                    gap_pending = 1'b0;
                end
                if (bus.mem_valid && bus.mem_ready) begin
                    gap_pending = 1'b1;
                    if (exp_reads.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: addr got %h, expected none", bus.mem_addr);
                    end else begin
                        ma = exp_reads.pop_front();
                        check32("read_addr", bus.mem_addr, ma);
                    end
                end
                if (bus.mem_req_ready) begin
                    if (exp_fills.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got pulse, expected none");
                    end else begin
                        mf = exp_fills.pop_front();
                        checks++;
                        if (bus.mem_req_rdata !== mf.line) begin
                            errors++;
                            $display("FAIL line_rdata: got %h, expected %h",
                                     bus.mem_req_rdata, mf.line);
                        end
                        check32("fill_latency", 32'(cyc - mf.start), 32'(mf.lat));
                    end
                end
            end
        end
    end

    task automatic set_mem(input int lat, input bit stuck);
        mem_lat   = lat;
        mem_stuck = stuck;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_req_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no pulse, expected one within 200 cycles");
        end
    endtask

    task automatic queue_fill(input logic [31:0] addr, input int lat, input bit stuck);
        fill_exp_t f;
        push_reads(addr, NB);
        f.line  = exp_line(base_of(addr));
        f.start = cyc;
        f.lat   = NB * ((stuck ? 0 : lat) + 2) + 1;
        exp_fills.push_back(f);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = addr;
    endtask

    task automatic fill(input logic [31:0] addr, input int lat, input bit stuck);
        set_mem(lat, stuck);
        queue_fill(addr, lat, stuck);
        wait_ready();
        bus.mem_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mem_req_rdata !== exp_line(base_of(addr))) begin
            errors++;
            $display("FAIL rdata_hold: got %h, expected %h",
                     bus.mem_req_rdata, exp_line(base_of(addr)));
        end
    endtask

    initial begin
        bit quiet;
        bit hs;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check32("reset_req_ready", 32'(bus.mem_req_ready), 32'd0);
        check32("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
        check32("reset_mem_addr", bus.mem_addr, 32'd0);
        checks++;
        if (bus.mem_req_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h, expected 0", bus.mem_req_rdata);
        end
        reset = 1'b0;
        @(negedge clk);

        fill(32'h0000_0004, 1, 1'b0);
        fill(32'h0000_0018, 1, 1'b0);

        // Back-to-back: old request held through DONE and GAP, new one presented in IDLE.
        set_mem(1, 1'b0);
        queue_fill(32'h0000_0008, 1, 1'b0);
        wait_ready();
        @(negedge clk);
        @(negedge clk);
        queue_fill(32'h0000_0020, 1, 1'b0);
        wait_ready();
        bus.mem_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Abort after the first beat.
        set_mem(3, 1'b0);
        push_reads(32'h0000_0030, 1);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = 32'h0000_0030;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_ready) hs = 1'b1;
        end
        check32("abort_first_beat", 32'(hs), 32'd1);
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_valid) quiet = 1'b0;
        end
        check32("abort_quiet", 32'(quiet), 32'd1);
        fill(32'h0000_0050, 2, 1'b0);

        // Reset while a read is outstanding.
        set_mem(3, 1'b0);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = 32'h0000_0048;
        @(negedge clk);
        check32("pre_reset_mem_valid", 32'(bus.mem_valid), 32'd1);
        #2;
        reset = 1'b1;
        bus.mem_req_valid = 1'b0;
        #1;
        check32("async_req_ready", 32'(bus.mem_req_ready), 32'd0);
        check32("async_mem_valid", 32'(bus.mem_valid), 32'd0);
        check32("async_mem_addr", bus.mem_addr, 32'd0);
        checks++;
        if (bus.mem_req_rdata !== '0) begin
            errors++;
            $display("FAIL async_rdata: got %h, expected 0", bus.mem_req_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill(32'h0000_0040, 1, 1'b0);

        fill(32'h0000_0064, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            fill($urandom(), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        set_mem(1, 1'b0);
        repeat (5) @(negedge clk);
        check32("reads_drained", 32'(exp_reads.size()), 32'd0);
        check32("fills_drained", 32'(exp_fills.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
